simmem_latency_queue: RTL and testbench
=======================================

SIMMEM_LATENCY_QUEUE -- requirements
Module: simmem_latency_queue

Interface
REQ-001 Parameter NumCh, default 2, number of independent channels (>=1).
REQ-002 Parameter DataW, default 32, payload width per channel.
REQ-003 Parameter Depth, default 8, entries per channel; power of two, >=2.
REQ-004 Parameter LatW, default 8, latency counter width per entry.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset; synchronous, active-low.
REQ-007 in_valid_i  input  NumCh  per-channel request valid.
REQ-008 in_ready_o  output  NumCh  per-channel accept ready.
REQ-009 in_data_i  input  NumCh*DataW  payloads; channel c at bits [c*DataW +: DataW].
REQ-010 lat_i  input  NumCh*LatW  per-channel latency in cycles; channel c at [c*LatW +: LatW].
REQ-011 bypass_i  input  NumCh  per-channel zero-latency mode.
REQ-012 out_valid_o  output  NumCh  per-channel release valid.
REQ-013 out_ready_i  input  NumCh  per-channel downstream ready.
REQ-014 out_data_o  output  NumCh*DataW  released payloads, same packing as in_data_i.
REQ-015 occupancy_o  output  NumCh*$clog2(Depth+1)  per-channel stored-entry count.

Function
REQ-016 Channels SHALL be fully independent; no shared state, no arbitration.
REQ-017 Each channel SHALL be an in-order FIFO of Depth entries; each entry holds payload plus LatW-bit countdown.
REQ-018 Accept SHALL occur on an edge where in_valid_i[c] & in_ready_o[c]; payload written at write pointer, countdown loaded with lat_i[c], or 0 when bypass_i[c]=1.
REQ-019 lat_i and bypass_i SHALL be sampled only at accept; later changes SHALL NOT affect stored entries.
REQ-020 Every stored entry with nonzero countdown SHALL decrement by 1 each edge, in parallel, saturating at 0; the countdown of an entry being accepted is not decremented that edge.
REQ-021 out_valid_o[c] SHALL be 1 iff channel c is non-empty and its head countdown is 0; entry accepted at edge k with latency L SHALL first be valid after edge k+L (L=0: after edge k).
REQ-022 No combinational path from in_valid_i/in_data_i to out_valid_o/out_data_o.
REQ-023 Head-of-line blocking: a younger entry SHALL NOT release before the head; its countdown still runs, so it releases the cycle after the head pops if already 0.
REQ-024 Pop SHALL occur on an edge where out_valid_o[c] & out_ready_i[c]; read pointer advances.
REQ-025 While out_valid_o[c]=1 and out_ready_i[c]=0, out_data_o[c] SHALL be stable.
REQ-026 out_data_o[c] SHALL be the head payload while non-empty; value when empty is don't-care.
REQ-027 in_ready_o[c] SHALL equal !full[c]; a pop in the same cycle SHALL NOT make a full channel ready (no pass-through).
REQ-028 Simultaneous accept and pop SHALL leave occupancy unchanged.
REQ-029 Pointers SHALL be log2(Depth)+1 bits with wrap bit; full = same index, differing wrap bit; empty = pointers equal.
REQ-030 occupancy_o[c] SHALL be registered and equal to accepts minus pops since reset, range 0..Depth.

Reset
REQ-031 While rst_ni=0 at an edge, all pointers, countdowns and occupancy SHALL clear; stored entries are discarded.
REQ-032 After reset: out_valid_o=0, in_ready_o=all ones, occupancy_o=0; payload storage not reset.
REQ-033 Reset asserted mid-operation SHALL drop in-flight entries with no release; first accept after reset behaves as from empty.

Verification
REQ-034 NumCh=2, lat_i[0]=3, accept D=0xA5 on ch0 at edge k, out_ready_i=1 -> out_valid_o[0] first 1 after edge k+3, data 0xA5; ch1 untouched.
REQ-035 bypass_i[0]=1, lat_i[0]=50, accept at edge k -> out_valid_o[0]=1 after edge k.
REQ-036 Ch0: accept A lat 10 then B lat 1, out_ready_i=1 -> A after 10 cycles, B the following cycle, order A,B.
REQ-037 Fill ch0 with 8 entries, out_ready_i=0 -> in_ready_o[0]=0, occupancy 8; one pop with in_valid_i=1 -> no accept that edge, in_ready_o=1 next cycle, occupancy 7.
REQ-038 Depth=8, 20 back-to-back accept/pop pairs, lat 0 -> pointers wrap, data order preserved, occupancy constant.
REQ-039 Three entries stored, rst_ni low one edge -> out_valid_o=0, occupancy_o=0, in_ready_o all ones next cycle; no stale release afterwards.

Source files
------------

// File: rtl/simmem_latency_queue.sv
// Per-channel latency-injecting FIFO: each accepted payload is held until its
// countdown expires and it reaches the head, then released in order.
module simmem_latency_queue #(
  parameter int unsigned NumCh = 2,
  parameter int unsigned DataW = 32,
  parameter int unsigned Depth = 8,
  parameter int unsigned LatW  = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumCh-1:0]                    in_valid_i,
  output logic [NumCh-1:0]                    in_ready_o,
  input  logic [NumCh*DataW-1:0]              in_data_i,
  input  logic [NumCh*LatW-1:0]               lat_i,
  input  logic [NumCh-1:0]                    bypass_i,
  output logic [NumCh-1:0]                    out_valid_o,
  input  logic [NumCh-1:0]                    out_ready_i,
  output logic [NumCh*DataW-1:0]              out_data_o,
  output logic [NumCh*$clog2(Depth+1)-1:0]    occupancy_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  logic [DataW-1:0] mem_q [NumCh][Depth];
  logic [LatW-1:0]  cnt_q [NumCh][Depth];
  logic [LatW-1:0]  cnt_d [NumCh][Depth];
  logic [AW:0]      wptr_q [NumCh];
  logic [AW:0]      wptr_d [NumCh];
  logic [AW:0]      rptr_q [NumCh];
  logic [AW:0]      rptr_d [NumCh];
  logic [OccW-1:0]  occ_q  [NumCh];
  logic [OccW-1:0]  occ_d  [NumCh];

  logic [NumCh-1:0] push;
  logic [NumCh-1:0] pop;
  logic [NumCh-1:0] full;
  logic [NumCh-1:0] empty;

  always_comb begin
    push        = '0;
    pop         = '0;
    full        = '0;
    empty       = '0;
    in_ready_o  = '0;
    out_valid_o = '0;
    out_data_o  = '0;
    occupancy_o = '0;
    for (int unsigned c = 0; c < NumCh; c++) begin
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      occ_d[c]  = occ_q[c];
      for (int unsigned i = 0; i < Depth; i++) begin
        cnt_d[c][i] = '0;
      end
    end

    for (int unsigned c = 0; c < NumCh; c++) begin
      empty[c] = (wptr_q[c] == rptr_q[c]);
      full[c]  = (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]) &&
                 (wptr_q[c][AW] != rptr_q[c][AW]);
      // Ready depends only on stored state, so a same-cycle pop never frees a full channel.
      in_ready_o[c]  = !full[c];
      out_valid_o[c] = !empty[c] && (cnt_q[c][rptr_q[c][AW-1:0]] == '0);
      out_data_o[c*DataW +: DataW]  = mem_q[c][rptr_q[c][AW-1:0]];
      occupancy_o[c*OccW +: OccW]   = occ_q[c];

      push[c] = in_valid_i[c] && !full[c];
      pop[c]  = out_valid_o[c] && out_ready_i[c];

      wptr_d[c] = wptr_q[c] + {{AW{1'b0}}, push[c]};
      rptr_d[c] = rptr_q[c] + {{AW{1'b0}}, pop[c]};
      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + {{(OccW-1){1'b0}}, 1'b1};
        2'b01:   occ_d[c] = occ_q[c] - {{(OccW-1){1'b0}}, 1'b1};
        default: occ_d[c] = occ_q[c];
      endcase

      // Free slots count down too; harmless because a write reloads them.
      for (int unsigned i = 0; i < Depth; i++) begin
        cnt_d[c][i] = (cnt_q[c][i] != '0) ? cnt_q[c][i] - 1'b1 : '0;
      end
      if (push[c]) begin
        cnt_d[c][wptr_q[c][AW-1:0]] = bypass_i[c] ? '0 : lat_i[c*LatW +: LatW];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < NumCh; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        occ_q[c]  <= '0;
        for (int unsigned i = 0; i < Depth; i++) begin
          cnt_q[c][i] <= '0;
        end
      end
    end else begin
      for (int unsigned c = 0; c < NumCh; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        occ_q[c]  <= occ_d[c];
        for (int unsigned i = 0; i < Depth; i++) begin
          cnt_q[c][i] <= cnt_d[c][i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NumCh; c++) begin
      if (rst_ni && push[c]) begin
        mem_q[c][wptr_q[c][AW-1:0]] <= in_data_i[c*DataW +: DataW];
      end
    end
  end

endmodule

// File: tb/tb_simmem_latency_queue.sv
// Bench for simmem_latency_queue: directed scenarios plus random traffic
// checked against a release-time queue model.
module tb_simmem_latency_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [63:0] in_data;
  logic [15:0] lat;
  logic [1:0]  bypass;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [63:0] out_data;
  logic [7:0]  occ;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;

  // Model entry: {release edge number, payload}
  logic [63:0] mq [2][$];

  always #5 clk = ~clk;

  simmem_latency_queue #(.NumCh(2), .DataW(32), .Depth(8), .LatW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .lat_i(lat), .bypass_i(bypass),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .occupancy_o(occ)
  );

  function automatic bit m_valid(int c);
    if (mq[c].size() == 0) return 1'b0;
    return mq[c][0][63:32] <= cyc;
  endfunction

  function automatic logic [31:0] m_data(int c);
    logic [63:0] e;
    if (mq[c].size() == 0) return 'x;
    e = mq[c][0];
    return e[31:0];
  endfunction

  function automatic bit m_ready(int c);
    return mq[c].size() < 8;
  endfunction

  task automatic tick();
    bit acc [2];
    bit pp  [2];
    for (int c = 0; c < 2; c++) begin
      acc[c] = in_valid[c] && m_ready(c);
      pp[c]  = m_valid(c) && out_ready[c];
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (pp[c]) void'(mq[c].pop_front());
        if (acc[c]) mq[c].push_back({cyc + (bypass[c] ? 32'd0 : 32'(lat[c*8 +: 8])),
                                     in_data[c*32 +: 32]});
      end
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 2'b11;
    for (int i = 0; i < 80 && (mq[0].size() != 0 || mq[1].size() != 0); i++) tick();
    out_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; out_ready = '0; bypass = '0; lat = '0; in_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got=%b exp=00", out_valid); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got=%b exp=11", in_ready); end
    checks++; if (occ !== 8'h00) begin errors++; $display("FAIL reset_occ got=%h exp=00", occ); end
  endtask

  task automatic test_latency();
    out_ready = 2'b11; lat = 16'h0003; in_data = {32'h0, 32'hA5}; in_valid = 2'b01;
    tick();
    in_valid = '0;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (out_valid[0] !== (i == 3)) begin
        errors++; $display("FAIL lat3_valid edge+%0d got=%b exp=%b", i, out_valid[0], (i == 3));
      end
    end
    checks++; if (out_data[31:0] !== 32'hA5) begin errors++; $display("FAIL lat3_data got=%h exp=a5", out_data[31:0]); end
    checks++; if (out_valid[1] !== 1'b0 || occ[7:4] !== 4'd0) begin
      errors++; $display("FAIL lat3_ch1 valid=%b occ=%0d exp 0/0", out_valid[1], occ[7:4]);
    end
    tick();
    checks++; if (occ[3:0] !== 4'd0) begin errors++; $display("FAIL lat3_pop occ got=%0d exp=0", occ[3:0]); end
  endtask

  task automatic test_bypass();
    out_ready = 2'b00; lat = 16'd50; bypass = 2'b01; in_data = {32'h0, 32'h1234_5678}; in_valid = 2'b01;
    tick();
    in_valid = '0; lat = 16'd0; bypass = '0;
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", out_valid[0]); end
    checks++; if (out_data[31:0] !== 32'h1234_5678) begin errors++; $display("FAIL bypass_data got=%h exp=12345678", out_data[31:0]); end
    drain();
  endtask

  task automatic test_hol();
    int unsigned k;
    logic [63:0] got [$];
    out_ready = 2'b11;
    lat = 16'd10; in_data = {32'h0, 32'hAAAA_0001}; in_valid = 2'b01;
    tick();
    k = cyc;
    lat = 16'd1; in_data = {32'h0, 32'hBBBB_0002};
    tick();
    in_valid = '0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid[0]) got.push_back({cyc - k, out_data[31:0]});
      tick();
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL hol_count got=%0d exp=2", got.size());
    end else begin
      checks++; if (got[0] !== {32'd10, 32'hAAAA_0001}) begin errors++; $display("FAIL hol_first got=%h exp=0000000aaaaa0001", got[0]); end
      checks++; if (got[1] !== {32'd11, 32'hBBBB_0002}) begin errors++; $display("FAIL hol_second got=%h exp=0000000bbbbb0002", got[1]); end
    end
  endtask

  task automatic test_full();
    out_ready = 2'b00; lat = '0; in_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      in_data = {32'h0, 32'hF000_0000 + 32'(i)};
      tick();
    end
    checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in_ready[0]); end
    checks++; if (occ[3:0] !== 4'd8) begin errors++; $display("FAIL full_occ got=%0d exp=8", occ[3:0]); end
    in_data = {32'h0, 32'hDEAD_BEEF}; out_ready = 2'b01;
    tick();
    in_valid = '0; out_ready = '0;
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", in_ready[0]); end
    checks++; if (occ[3:0] !== 4'd7) begin errors++; $display("FAIL full_pop_occ got=%0d exp=7", occ[3:0]); end
    out_ready = 2'b01;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'hF000_0000 + 32'(i)) begin
        errors++; $display("FAIL full_drain[%0d] valid=%b data=%h exp 1/%h", i, out_valid[0], out_data[31:0], 32'hF000_0000 + 32'(i));
      end
      tick();
    end
    checks++; if (occ[3:0] !== 4'd0 || out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL full_empty occ=%0d valid=%b exp 0/0", occ[3:0], out_valid[0]);
    end
    out_ready = '0;
  endtask

  task automatic test_back_to_back();
    out_ready = 2'b01; lat = '0; in_valid = 2'b01;
    in_data = {32'h0, 32'hC000_0000};
    tick();
    for (int i = 1; i <= 20; i++) begin
      in_data = {32'h0, 32'hC000_0000 + 32'(i)};
      checks++;
      if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'hC000_0000 + 32'(i - 1) || occ[3:0] !== 4'd1) begin
        errors++; $display("FAIL b2b[%0d] valid=%b data=%h occ=%0d exp 1/%h/1", i, out_valid[0], out_data[31:0], occ[3:0], 32'hC000_0000 + 32'(i - 1));
      end
      tick();
    end
    drain();
    checks++; if (occ !== 8'h00) begin errors++; $display("FAIL b2b_end occ got=%h exp=00", occ); end
  endtask

  task automatic test_reset_mid();
    out_ready = '0; lat = 16'h0202; in_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_data = {32'h7700_0000 + 32'(i), 32'h6600_0000 + 32'(i)};
      tick();
    end
    in_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_valid got=%b exp=00", out_valid); end
    checks++; if (occ !== 8'h00) begin errors++; $display("FAIL rstmid_occ got=%h exp=00", occ); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL rstmid_ready got=%b exp=11", in_ready); end
    out_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 2'b00) begin errors++; $display("FAIL rstmid_stale[%0d] got=%b exp=00", i, out_valid); end
      tick();
    end
    in_data = {32'h0, 32'h0000_0042}; lat = '0; in_valid = 2'b01;
    tick();
    in_valid = '0;
    checks++; if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'h42) begin
      errors++; $display("FAIL rstmid_first valid=%b data=%h exp 1/42", out_valid[0], out_data[31:0]);
    end
    drain();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = 2'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom);
      in_data   = {$urandom, $urandom};
      lat       = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      bypass    = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (out_valid[c] !== m_valid(c) || in_ready[c] !== m_ready(c) ||
            occ[c*4 +: 4] !== 4'(mq[c].size()) ||
            (m_valid(c) && out_data[c*32 +: 32] !== m_data(c))) begin
          errors++;
          $display("FAIL rand[%0d] ch%0d valid=%b/%b ready=%b/%b occ=%0d/%0d data=%h/%h (got/exp)",
                   n, c, out_valid[c], m_valid(c), in_ready[c], m_ready(c),
                   occ[c*4 +: 4], mq[c].size(), out_data[c*32 +: 32], m_data(c));
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bypass();
    test_hol();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
